note_scheduler: RTL and testbench



---
 rtl/note_scheduler.sv | 138 +++++++++++++
 tb/tb_note_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/note_scheduler.sv
// Tempo-driven 8-step note sequencer: one note per step, silent gap at step end, writable loop pattern.
// Optional NOTE_SCHED_ONESHOT_EN: stop after step 7 instead of wrapping to step 0.
module note_scheduler #(
    parameter int unsigned TEMPO_DIV  = 1500000,
    parameter int unsigned GAP_CYCLES = 150000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       play_edge,
    input  logic [1:0] tempo_sel,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_note,
    output logic [3:0] note_out,
    output logic [2:0] step_idx,
    output logic       step_strobe,
    output logic       playing
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] REST = 4'hF;
    localparam logic [3:0] PATTERN_DEFAULT [8] = '{
        4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11, 4'd12
    };

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] cnt_q, cnt_d;
    logic        strobe_q, strobe_d;
    logic [1:0]  tsel_q, tsel_d;
    logic [3:0]  pattern_q [8];

    logic [31:0] step_len;
    logic [31:0] last_cnt;
    logic [31:0] gap_start_cnt;
    logic        at_boundary;
    logic        at_gap_start;

    // Step length follows the tempo latched at the last boundary, not the live input.
    assign step_len      = 32'(TEMPO_DIV) << tsel_q;
    assign last_cnt      = step_len - 32'd1;
    assign gap_start_cnt = step_len - 32'(GAP_CYCLES) - 32'd1;
    assign at_boundary   = (cnt_q == last_cnt);
    assign at_gap_start  = (GAP_CYCLES > 0) && (cnt_q == gap_start_cnt);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            step_q   <= 3'd0;
            cnt_q    <= 32'd0;
            strobe_q <= 1'b0;
            tsel_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            tsel_q   <= tsel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        tsel_d   = tsel_q;

        unique case (state_q)
            IDLE: begin
                cnt_d  = 32'd0;
                step_d = 3'd0;
                if (play_edge) begin
                    state_d  = PLAY;
                    strobe_d = 1'b1;
                    tsel_d   = tempo_sel;
                end
            end
            PLAY, GAP: begin
                // Stop has priority over a coincident step boundary.
                if (play_edge) begin
                    state_d = IDLE;
                    step_d  = 3'd0;
                    cnt_d   = 32'd0;
                end else if (at_boundary) begin
                    cnt_d  = 32'd0;
                    tsel_d = tempo_sel;
`ifdef NOTE_SCHED_ONESHOT_EN
                    if (step_q == 3'd7) begin
                        state_d = IDLE;
                        step_d  = 3'd0;
                    end else begin
                        state_d  = PLAY;
                        step_d   = step_q + 3'd1;
                        strobe_d = 1'b1;
                    end
`else
                    state_d  = PLAY;
                    step_d   = step_q + 3'd1;
                    strobe_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (state_q == PLAY && at_gap_start) begin
                        state_d = GAP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = 3'd0;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // Pattern slots: written in any state, reloaded only by reset.
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                pattern_q[gi] <= PATTERN_DEFAULT[gi];
            end else if (wr_en && (wr_addr == 3'(gi))) begin
                pattern_q[gi] <= wr_note;
            end
        end
    end

    assign note_out    = (state_q == PLAY) ? pattern_q[step_q] : REST;
    assign step_idx    = step_q;
    assign step_strobe = strobe_q;
    assign playing     = (state_q != IDLE);

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with TEMPO_DIV=8, GAP_CYCLES=2.
module tb_note_scheduler;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       play_edge;
    logic [1:0] tempo_sel;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_note;
    logic [3:0] note_out;
    logic [2:0] step_idx;
    logic       step_strobe;
    logic       playing;

    int checks = 0;
    int errors = 0;

    int def_note [8] = '{0, 2, 4, 5, 7, 9, 11, 12};

    note_scheduler #(.TEMPO_DIV(8), .GAP_CYCLES(2)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .play_edge  (play_edge),
        .tempo_sel  (tempo_sel),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_note    (wr_note),
        .note_out   (note_out),
        .step_idx   (step_idx),
        .step_strobe(step_strobe),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_play;
        play_edge = 1'b1;
        tick();
        play_edge = 1'b0;
    endtask

    // Checks one whole step cycle by cycle; optionally changes tempo_sel after cycle chg_at.
    task automatic run_step(input int idx, input int note, input int len,
                            input int chg_at, input logic [1:0] chg_val);
        for (int k = 0; k < len; k++) begin
            check($sformatf("s%0d_k%0d_idx", idx, k), int'(step_idx), idx);
            check($sformatf("s%0d_k%0d_note", idx, k), int'(note_out), (k < len - 2) ? note : 15);
            check($sformatf("s%0d_k%0d_strobe", idx, k), int'(step_strobe), (k == 0) ? 1 : 0);
            check($sformatf("s%0d_k%0d_playing", idx, k), int'(playing), 1);
            if (k == chg_at) tempo_sel = chg_val;
            tick();
        end
        $display("step %0d note %0d len %0d checked", idx, note, len);
    endtask

    initial begin
        n_rst     = 1'b0;
        play_edge = 1'b0;
        tempo_sel = 2'd0;
        wr_en     = 1'b0;
        wr_addr   = 3'd0;
        wr_note   = 4'd0;
        #2;
        check("rst_note", int'(note_out), 15);
        check("rst_idx", int'(step_idx), 0);
        check("rst_strobe", int'(step_strobe), 0);
        check("rst_playing", int'(playing), 0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        check("idle_note", int'(note_out), 15);
        check("idle_playing", int'(playing), 0);
        $display("reset done");

        // Loop mode: steps 0..7 then wrap to 0.
        pulse_play();
        for (int s = 0; s < 9; s++) run_step(s % 8, def_note[s % 8], 8, -1, 2'd0);

        // Tempo change mid step 3 takes effect only at step 4.
        run_step(1, 2, 8, -1, 2'd0);
        run_step(2, 4, 8, -1, 2'd0);
        run_step(3, 5, 8, 3, 2'd2);
        run_step(4, 7, 32, 5, 2'd0);

        // Overwrite the sounding slot with a rest.
        check("s5_pre_note", int'(note_out), 9);
        wr_en = 1'b1; wr_addr = 3'd5; wr_note = 4'hF;
        tick();
        wr_en = 1'b0;
        check("rest_note", int'(note_out), 15);
        check("rest_playing", int'(playing), 1);
        $display("write rest to sounding slot 5");
        repeat (6) tick();
        wr_en = 1'b1; wr_addr = 3'd5; wr_note = 4'd3;
        tick();
        wr_en = 1'b0;
        $display("write note 3 to slot 5");
        run_step(6, 11, 8, -1, 2'd0);
        run_step(7, 12, 8, -1, 2'd0);
        run_step(0, 0, 8, -1, 2'd0);
        run_step(1, 2, 8, -1, 2'd0);
        run_step(2, 4, 8, -1, 2'd0);
        run_step(3, 5, 8, -1, 2'd0);
        run_step(4, 7, 8, -1, 2'd0);
        run_step(5, 3, 8, -1, 2'd0);

        // Stop on the exact boundary cycle.
        repeat (7) tick();
        pulse_play();
        check("stop_playing", int'(playing), 0);
        check("stop_idx", int'(step_idx), 0);
        check("stop_strobe", int'(step_strobe), 0);
        check("stop_note", int'(note_out), 15);
        repeat (3) tick();
        check("idle2_strobe", int'(step_strobe), 0);
        check("idle2_playing", int'(playing), 0);
        $display("stop on boundary");

        // Write while idle, then reset mid-gap.
        wr_en = 1'b1; wr_addr = 3'd0; wr_note = 4'd7;
        tick();
        wr_en = 1'b0;
        pulse_play();
        run_step(0, 7, 8, -1, 2'd0);
        repeat (6) tick();
        check("gap_note", int'(note_out), 15);
        check("gap_playing", int'(playing), 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_note", int'(note_out), 15);
        check("arst_idx", int'(step_idx), 0);
        check("arst_strobe", int'(step_strobe), 0);
        check("arst_playing", int'(playing), 0);
        $display("async reset mid gap");
        tick();
        n_rst = 1'b1;
        tick();
        pulse_play();
        for (int s = 0; s < 9; s++) run_step(s % 8, def_note[s % 8], 8, -1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
